// File: rtl/i2c_cmd_engine.sv
// rtl/i2c_cmd_engine.sv - command decoder, I2C transaction sequencer and result uploader
module i2c_cmd_engine #(
    parameter int unsigned SYS_CLK_FREQ = 50_000_000,
    parameter int unsigned BUF_DEPTH    = 64,
    parameter int unsigned TIMEOUT_CYC  = 1_000_000,
    parameter logic [7:0]  DATA_SRC     = 8'h05,
    parameter logic [7:0]  STAT_SRC     = 8'h06
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd_type,
    input  logic [15:0] cmd_length,
    input  logic [7:0]  cmd_data,
    input  logic [15:0] cmd_data_index,
    input  logic        cmd_start,
    input  logic        cmd_data_valid,
    input  logic        cmd_done,
    output logic        cmd_ready,
    output logic        txn_req,
    output logic        txn_rw,
    output logic [6:0]  txn_dev,
    output logic        txn_use_addr,
    output logic [15:0] txn_addr,
    output logic        txn_addr16,
    output logic [15:0] txn_len,
    output logic [15:0] scl_div,
    input  logic [7:0]  txn_wr_idx,
    output logic [7:0]  txn_wr_byte,
    input  logic        txn_rd_valid,
    input  logic [7:0]  txn_rd_byte,
    input  logic        txn_done,
    input  logic        txn_nack,
    output logic        txn_abort,
    output logic        upload_active,
    output logic        upload_req,
    output logic [7:0]  upload_data,
    output logic [7:0]  upload_source,
    output logic        upload_valid,
    input  logic        upload_ready
);

    localparam int unsigned AW       = $clog2(BUF_DEPTH);
    localparam int unsigned CW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [15:0] DEPTH16  = 16'(BUF_DEPTH);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [15:0] DIV_RST  = 16'(SYS_CLK_FREQ / 400_000 - 1);
    localparam logic [15:0] DIV_100K = 16'(SYS_CLK_FREQ / 400_000 - 1);
    localparam logic [15:0] DIV_400K = 16'(SYS_CLK_FREQ / 1_600_000 - 1);
    localparam logic [15:0] DIV_1M   = 16'(SYS_CLK_FREQ / 4_000_000 - 1);

    localparam logic [7:0] CMD_WR  = 8'h02;
    localparam logic [7:0] CMD_RD  = 8'h03;
    localparam logic [7:0] CMD_CFG = 8'h04;
    localparam logic [7:0] CMD_WRA = 8'h05;
    localparam logic [7:0] CMD_RDA = 8'h06;

    typedef enum logic [2:0] {ST_IDLE, ST_PARSE, ST_EXEC, ST_UPLOAD, ST_STATUS} state_t;

    state_t        state_q, state_d;
    logic [7:0]    type_q, type_d;
    logic [15:0]   clen_q, clen_d;
    logic [6:0]    dev_q, dev_d;
    logic          addr16_q, addr16_d;
    logic [15:0]   scl_div_q, scl_div_d;
    logic [7:0]    addr_hi_q, addr_hi_d;
    logic [7:0]    addr_lo_q, addr_lo_d;
    logic [15:0]   len_q, len_d;
    logic          nack_q, nack_d;
    logic          tout_q, tout_d;
    logic          trunc_q, trunc_d;
    logic          txn_req_q, txn_req_d;
    logic          txn_abort_q, txn_abort_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   rd_idx_q, rd_idx_d;
    logic [15:0]   up_idx_q, up_idx_d;

    logic [7:0]    wr_buf_q [BUF_DEPTH];
    logic [7:0]    rd_buf_q [BUF_DEPTH];
    logic          wr_we, rd_we;
    logic [AW-1:0] wr_waddr, rd_waddr;
    logic [15:0]   req_len, data_idx;
    logic          is_read, valid_code;

    assign is_read    = (type_q == CMD_RD) || (type_q == CMD_RDA);
    assign valid_code = (cmd_type == CMD_WR) || (cmd_type == CMD_RD) || (cmd_type == CMD_CFG) ||
                        (cmd_type == CMD_WRA) || (cmd_type == CMD_RDA);

    // Control state register; reset lands in IDLE from anywhere without an abort pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            type_q      <= 8'h00;
            clen_q      <= 16'h0000;
            dev_q       <= 7'h00;
            addr16_q    <= 1'b1;
            scl_div_q   <= DIV_RST;
            addr_hi_q   <= 8'h00;
            addr_lo_q   <= 8'h00;
            len_q       <= 16'h0000;
            nack_q      <= 1'b0;
            tout_q      <= 1'b0;
            trunc_q     <= 1'b0;
            txn_req_q   <= 1'b0;
            txn_abort_q <= 1'b0;
            cnt_q       <= '0;
            rd_idx_q    <= 16'h0000;
            up_idx_q    <= 16'h0000;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            clen_q      <= clen_d;
            dev_q       <= dev_d;
            addr16_q    <= addr16_d;
            scl_div_q   <= scl_div_d;
            addr_hi_q   <= addr_hi_d;
            addr_lo_q   <= addr_lo_d;
            len_q       <= len_d;
            nack_q      <= nack_d;
            tout_q      <= tout_d;
            trunc_q     <= trunc_d;
            txn_req_q   <= txn_req_d;
            txn_abort_q <= txn_abort_d;
            cnt_q       <= cnt_d;
            rd_idx_q    <= rd_idx_d;
            up_idx_q    <= up_idx_d;
        end
    end

    // Payload and read-data buffers; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_we) wr_buf_q[wr_waddr] <= cmd_data;
        if (rd_we) rd_buf_q[rd_waddr] <= txn_rd_byte;
    end

    // Next-state: command decode, payload parsing, transaction supervision, upload sequencing
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        clen_d      = clen_q;
        dev_d       = dev_q;
        addr16_d    = addr16_q;
        scl_div_d   = scl_div_q;
        addr_hi_d   = addr_hi_q;
        addr_lo_d   = addr_lo_q;
        len_d       = len_q;
        nack_d      = nack_q;
        tout_d      = tout_q;
        trunc_d     = trunc_q;
        txn_req_d   = 1'b0;
        txn_abort_d = 1'b0;
        cnt_d       = cnt_q;
        rd_idx_d    = rd_idx_q;
        up_idx_d    = up_idx_q;
        wr_we       = 1'b0;
        wr_waddr    = '0;
        rd_we       = 1'b0;
        rd_waddr    = '0;
        req_len     = 16'h0000;
        data_idx    = 16'h0000;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start && valid_code) begin
                    state_d = ST_PARSE;
                    type_d  = cmd_type;
                    clen_d  = cmd_length;
                    len_d   = 16'h0000;
                    nack_d  = 1'b0;
                    tout_d  = 1'b0;
                    trunc_d = 1'b0;
                end
            end
            ST_PARSE: begin
                if (cmd_data_valid) begin
                    case (type_q)
                        CMD_CFG: begin
                            if (cmd_data_index == 16'd0) dev_d = cmd_data[6:0];
                            if (cmd_data_index == 16'd1) addr16_d = (cmd_data == 8'd1);
                            if (cmd_data_index == 16'd2) begin
                                case (cmd_data)
                                    8'd1:    scl_div_d = DIV_100K;
                                    8'd2:    scl_div_d = DIV_400K;
                                    8'd3:    scl_div_d = DIV_1M;
                                    default: scl_div_d = scl_div_q;
                                endcase
                            end
                        end
                        CMD_RD: begin
                            if (cmd_data_index == 16'd0) len_d[15:8] = cmd_data;
                            if (cmd_data_index == 16'd1) len_d[7:0]  = cmd_data;
                        end
                        CMD_RDA: begin
                            if (cmd_data_index == 16'd0) addr_hi_d   = cmd_data;
                            if (cmd_data_index == 16'd1) addr_lo_d   = cmd_data;
                            if (cmd_data_index == 16'd2) len_d[15:8] = cmd_data;
                            if (cmd_data_index == 16'd3) len_d[7:0]  = cmd_data;
                        end
                        default: begin
                            // Writes: the addressed form carries two address bytes ahead of the data
                            if (type_q == CMD_WRA && cmd_data_index == 16'd0) addr_hi_d = cmd_data;
                            if (type_q == CMD_WRA && cmd_data_index == 16'd1) addr_lo_d = cmd_data;
                            if (type_q == CMD_WR || cmd_data_index >= 16'd2) begin
                                data_idx = (type_q == CMD_WRA) ? cmd_data_index - 16'd2 : cmd_data_index;
                                if (data_idx < DEPTH16) begin
                                    wr_we    = 1'b1;
                                    wr_waddr = data_idx[AW-1:0];
                                end else begin
                                    trunc_d = 1'b1;
                                end
                            end
                        end
                    endcase
                end
                if (cmd_done) begin
                    if (type_q == CMD_CFG) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (type_q == CMD_WR)       req_len = clen_q;
                        else if (type_q == CMD_WRA) req_len = (clen_q >= 16'd2) ? clen_q - 16'd2 : 16'd0;
                        else                        req_len = len_d;
                        if (req_len > DEPTH16) begin
                            req_len = DEPTH16;
                            trunc_d = 1'b1;
                        end
                        len_d    = req_len;
                        cnt_d    = '0;
                        rd_idx_d = 16'h0000;
                        if (req_len == 16'h0000) begin
                            state_d = ST_STATUS;
                        end else begin
                            state_d   = ST_EXEC;
                            txn_req_d = 1'b1;
                        end
                    end
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q + CW'(1);
                if (txn_rd_valid && rd_idx_q < len_q) begin
                    rd_we    = 1'b1;
                    rd_waddr = rd_idx_q[AW-1:0];
                    rd_idx_d = rd_idx_q + 16'd1;
                end
                if (txn_done) begin
                    nack_d   = txn_nack;
                    up_idx_d = 16'h0000;
                    state_d  = (is_read && !txn_nack) ? ST_UPLOAD : ST_STATUS;
                end else if (cnt_q == TMO_LAST) begin
                    txn_abort_d = 1'b1;
                    tout_d      = 1'b1;
                    state_d     = ST_STATUS;
                end
            end
            ST_UPLOAD: begin
                if (upload_ready) begin
                    if (up_idx_q == len_q - 16'd1) state_d = ST_STATUS;
                    else                           up_idx_d = up_idx_q + 16'd1;
                end
            end
            ST_STATUS: begin
                if (upload_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: upload data is held by the index register until the handshake
    always_comb begin
        upload_valid  = 1'b0;
        upload_data   = 8'h00;
        upload_source = DATA_SRC;
        if (state_q == ST_UPLOAD) begin
            upload_valid = 1'b1;
            upload_data  = rd_buf_q[up_idx_q[AW-1:0]];
        end else if (state_q == ST_STATUS) begin
            upload_valid  = 1'b1;
            upload_data   = {5'b00000, trunc_q, tout_q, nack_q};
            upload_source = STAT_SRC;
        end
    end

    assign cmd_ready     = (state_q == ST_IDLE) || (state_q == ST_PARSE);
    assign upload_active = (state_q == ST_UPLOAD) || (state_q == ST_STATUS);
    assign upload_req    = upload_active;
    assign txn_req       = txn_req_q;
    assign txn_abort     = txn_abort_q;
    assign txn_rw        = is_read;
    assign txn_dev       = dev_q;
    assign txn_use_addr  = (type_q == CMD_WRA) || (type_q == CMD_RDA);
    assign txn_addr      = addr16_q ? {addr_hi_q, addr_lo_q} : {8'h00, addr_lo_q};
    assign txn_addr16    = addr16_q;
    assign txn_len       = len_q;
    assign scl_div       = scl_div_q;
    assign txn_wr_byte   = ({8'h00, txn_wr_idx} < DEPTH16) ? wr_buf_q[txn_wr_idx[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_i2c_cmd_engine.sv
// tb/tb_i2c_cmd_engine.sv - scoreboard bench for i2c_cmd_engine
module tb_i2c_cmd_engine;

    localparam logic [7:0] DSRC = 8'h05;
    localparam logic [7:0] SSRC = 8'h06;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cmd_type = 8'h00;
    logic [15:0] cmd_length = 16'h0000;
    logic [7:0]  cmd_data = 8'h00;
    logic [15:0] cmd_data_index = 16'h0000;
    logic        cmd_start = 1'b0, cmd_data_valid = 1'b0, cmd_done = 1'b0;
    logic        cmd_ready;
    logic        txn_req, txn_rw, txn_use_addr, txn_addr16, txn_abort;
    logic [6:0]  txn_dev;
    logic [15:0] txn_addr, txn_len, scl_div;
    logic [7:0]  txn_wr_idx = 8'h00;
    logic [7:0]  txn_wr_byte;
    logic        txn_rd_valid = 1'b0;
    logic [7:0]  txn_rd_byte = 8'h00;
    logic        txn_done = 1'b0, txn_nack = 1'b0;
    logic        upload_active, upload_req, upload_valid;
    logic [7:0]  upload_data, upload_source;
    logic        upload_ready = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0]  pay [$];
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    i2c_cmd_engine #(
        .SYS_CLK_FREQ(50_000_000), .BUF_DEPTH(64), .TIMEOUT_CYC(100),
        .DATA_SRC(8'h05), .STAT_SRC(8'h06)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_type(cmd_type), .cmd_length(cmd_length), .cmd_data(cmd_data),
        .cmd_data_index(cmd_data_index), .cmd_start(cmd_start),
        .cmd_data_valid(cmd_data_valid), .cmd_done(cmd_done), .cmd_ready(cmd_ready),
        .txn_req(txn_req), .txn_rw(txn_rw), .txn_dev(txn_dev), .txn_use_addr(txn_use_addr),
        .txn_addr(txn_addr), .txn_addr16(txn_addr16), .txn_len(txn_len), .scl_div(scl_div),
        .txn_wr_idx(txn_wr_idx), .txn_wr_byte(txn_wr_byte),
        .txn_rd_valid(txn_rd_valid), .txn_rd_byte(txn_rd_byte),
        .txn_done(txn_done), .txn_nack(txn_nack), .txn_abort(txn_abort),
        .upload_active(upload_active), .upload_req(upload_req), .upload_data(upload_data),
        .upload_source(upload_source), .upload_valid(upload_valid), .upload_ready(upload_ready)
    );

    task automatic send_cmd(input logic [7:0] ctype);
        @(negedge clk);
        cmd_type   = ctype;
        cmd_length = 16'(pay.size());
        cmd_start  = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        for (int i = 0; i < pay.size(); i++) begin
            cmd_data       = pay[i];
            cmd_data_index = 16'(i);
            cmd_data_valid = 1'b1;
            @(negedge clk);
        end
        cmd_data_valid = 1'b0;
        cmd_done       = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (txn_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (txn_req !== 1'b1) begin
            $display("FAIL %s_txn_req: got %b want 1", name, txn_req);
            tests_failed++;
        end
    endtask

    task automatic finish_txn(input logic nack);
        txn_rd_valid = 1'b0;
        txn_done     = 1'b1;
        txn_nack     = nack;
        @(negedge clk);
        txn_done = 1'b0;
        txn_nack = 1'b0;
    endtask

    task automatic run_upload(input bit toggle, input string name);
        int cyc = 0;
        bit r;
        bit holding = 1'b0;
        logic [7:0] held = 8'h00;
        logic [15:0] exp;
        while (sb.size() != 0 && cyc < 400) begin
            r = toggle ? ((cyc % 2) == 0) : 1'b1;
            upload_ready = r;
            if (upload_valid === 1'b1) begin
                tests_run++;
                if (upload_active !== 1'b1 || upload_req !== 1'b1) begin
                    $display("FAIL %s_active: got %b/%b want 1/1", name, upload_active, upload_req);
                    tests_failed++;
                end
                if (holding) begin
                    tests_run++;
                    if (upload_data !== held) begin
                        $display("FAIL %s_hold: got %h want %h", name, upload_data, held);
                        tests_failed++;
                    end
                end
                if (r) begin
                    exp = sb.pop_front();
                    holding = 1'b0;
                    tests_run++;
                    if ({upload_source, upload_data} !== exp) begin
                        $display("FAIL %s_byte: got %h:%h want %h:%h", name,
                                 upload_source, upload_data, exp[15:8], exp[7:0]);
                        tests_failed++;
                    end
                end else begin
                    holding = 1'b1;
                    held = upload_data;
                end
            end
            @(negedge clk);
            cyc++;
        end
        upload_ready = 1'b0;
        tests_run++;
        if (sb.size() != 0) begin
            $display("FAIL %s_timeout: got %0d bytes outstanding want 0", name, sb.size());
            tests_failed++;
            sb.delete();
        end
        tests_run++;
        if (upload_active !== 1'b0 || cmd_ready !== 1'b1) begin
            $display("FAIL %s_idle: got active=%b ready=%b want 0/1", name, upload_active, cmd_ready);
            tests_failed++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({cmd_ready, txn_req, txn_abort, upload_req, upload_active, upload_valid} !== 6'b100000) begin
            $display("FAIL reset_ctrl: got %b want 100000",
                     {cmd_ready, txn_req, txn_abort, upload_req, upload_active, upload_valid});
            tests_failed++;
        end
        tests_run++;
        if (upload_data !== 8'h00 || upload_source !== DSRC) begin
            $display("FAIL reset_upload: got %h/%h want 00/05", upload_data, upload_source);
            tests_failed++;
        end
        tests_run++;
        if (scl_div !== 16'd124 || txn_addr16 !== 1'b1 || txn_dev !== 7'h00) begin
            $display("FAIL reset_cfg: got div=%0d a16=%b dev=%h want 124/1/00", scl_div, txn_addr16, txn_dev);
            tests_failed++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_config_read();
        logic [7:0] rd [$];
        pay = '{8'h50, 8'h01, 8'h02};
        send_cmd(8'h04);
        tests_run++;
        if (scl_div !== 16'd30 || txn_dev !== 7'h50 || txn_addr16 !== 1'b1) begin
            $display("FAIL cfg: got div=%0d dev=%h a16=%b want 30/50/1", scl_div, txn_dev, txn_addr16);
            tests_failed++;
        end
        pay = '{8'h00, 8'h10, 8'h00, 8'h03};
        rd  = '{8'hA1, 8'hB2, 8'hC3};
        foreach (rd[i]) sb.push_back({DSRC, rd[i]});
        sb.push_back({SSRC, 8'h00});
        send_cmd(8'h06);
        wait_req("cfg_read");
        tests_run++;
        if (txn_dev !== 7'h50 || txn_addr !== 16'h0010 || txn_len !== 16'd3 ||
            txn_rw !== 1'b1 || txn_use_addr !== 1'b1) begin
            $display("FAIL cfg_read_txn: got dev=%h addr=%h len=%0d rw=%b ua=%b want 50/0010/3/1/1",
                     txn_dev, txn_addr, txn_len, txn_rw, txn_use_addr);
            tests_failed++;
        end
        for (int i = 0; i < rd.size(); i++) begin
            txn_rd_valid = 1'b1;
            txn_rd_byte  = rd[i];
            @(negedge clk);
            if (i == 0) begin
                tests_run++;
                if (txn_req !== 1'b0) begin
                    $display("FAIL cfg_read_req_pulse: got %b want 0", txn_req);
                    tests_failed++;
                end
            end
        end
        finish_txn(1'b0);
        run_upload(1'b0, "cfg_read");
    endtask

    task automatic test_write_nack();
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        sb.push_back({SSRC, 8'h01});
        send_cmd(8'h02);
        wait_req("wr_nack");
        tests_run++;
        if (txn_rw !== 1'b0 || txn_len !== 16'd4 || txn_use_addr !== 1'b0) begin
            $display("FAIL wr_nack_txn: got rw=%b len=%0d ua=%b want 0/4/0", txn_rw, txn_len, txn_use_addr);
            tests_failed++;
        end
        for (int i = 0; i < 4; i++) begin
            txn_wr_idx = 8'(i);
            #1;
            tests_run++;
            if (txn_wr_byte !== pay[i]) begin
                $display("FAIL wr_nack_byte%0d: got %h want %h", i, txn_wr_byte, pay[i]);
                tests_failed++;
            end
        end
        @(negedge clk);
        finish_txn(1'b1);
        run_upload(1'b0, "wr_nack");
    endtask

    task automatic test_timeout();
        int k = 0;
        pay = '{8'h00, 8'h02};
        sb.push_back({SSRC, 8'h02});
        send_cmd(8'h03);
        wait_req("timeout");
        while (txn_abort !== 1'b1 && k < 150) begin
            @(negedge clk);
            k++;
        end
        tests_run++;
        if (k != 100) begin
            $display("FAIL timeout_cycle: got %0d want 100", k);
            tests_failed++;
        end
        @(negedge clk);
        tests_run++;
        if (txn_abort !== 1'b0) begin
            $display("FAIL timeout_pulse: got %b want 0", txn_abort);
            tests_failed++;
        end
        run_upload(1'b0, "timeout");
    endtask

    task automatic test_trunc_toggle();
        pay = '{8'h00, 8'h50};
        for (int i = 0; i < 64; i++) sb.push_back({DSRC, 8'(i * 3 + 1)});
        sb.push_back({SSRC, 8'h04});
        send_cmd(8'h03);
        wait_req("trunc");
        tests_run++;
        if (txn_len !== 16'd64) begin
            $display("FAIL trunc_len: got %0d want 64", txn_len);
            tests_failed++;
        end
        for (int i = 0; i < 66; i++) begin
            txn_rd_valid = 1'b1;
            txn_rd_byte  = (i < 64) ? 8'(i * 3 + 1) : 8'hEE;
            @(negedge clk);
        end
        finish_txn(1'b0);
        run_upload(1'b1, "trunc");
    endtask

    task automatic test_write_addr_8bit();
        pay = '{8'h20, 8'h00, 8'h03};
        send_cmd(8'h04);
        tests_run++;
        if (scl_div !== 16'd11 || txn_addr16 !== 1'b0) begin
            $display("FAIL cfg8_div: got div=%0d a16=%b want 11/0", scl_div, txn_addr16);
            tests_failed++;
        end
        pay = '{8'h12, 8'h34, 8'h5A};
        sb.push_back({SSRC, 8'h00});
        send_cmd(8'h05);
        wait_req("wra8");
        txn_wr_idx = 8'd0;
        #1;
        tests_run++;
        if (txn_addr !== 16'h0034 || txn_len !== 16'd1 || txn_wr_byte !== 8'h5A || txn_dev !== 7'h20) begin
            $display("FAIL wra8_txn: got addr=%h len=%0d b0=%h dev=%h want 0034/1/5a/20",
                     txn_addr, txn_len, txn_wr_byte, txn_dev);
            tests_failed++;
        end
        @(negedge clk);
        finish_txn(1'b0);
        run_upload(1'b0, "wra8");
    endtask

    task automatic test_reset_mid_upload();
        pay = '{8'h00, 8'h03};
        send_cmd(8'h03);
        wait_req("rst_up");
        for (int i = 0; i < 3; i++) begin
            txn_rd_valid = 1'b1;
            txn_rd_byte  = 8'h60 + 8'(i);
            @(negedge clk);
        end
        finish_txn(1'b0);
        upload_ready = 1'b1;
        tests_run++;
        if (upload_valid !== 1'b1 || upload_data !== 8'h60) begin
            $display("FAIL rst_up_b0: got v=%b d=%h want 1/60", upload_valid, upload_data);
            tests_failed++;
        end
        @(negedge clk);
        upload_ready = 1'b0;
        tests_run++;
        if (upload_data !== 8'h61) begin
            $display("FAIL rst_up_b1: got %h want 61", upload_data);
            tests_failed++;
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (upload_valid !== 1'b0 || cmd_ready !== 1'b1 || upload_active !== 1'b0 || txn_abort !== 1'b0) begin
            $display("FAIL rst_up_idle: got v=%b rdy=%b act=%b abort=%b want 0/1/0/0",
                     upload_valid, cmd_ready, upload_active, txn_abort);
            tests_failed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pay = '{8'h12, 8'h34, 8'hAA, 8'hBB};
        sb.push_back({SSRC, 8'h00});
        send_cmd(8'h05);
        wait_req("post_rst");
        txn_wr_idx = 8'd1;
        #1;
        tests_run++;
        if (txn_addr !== 16'h1234 || txn_len !== 16'd2 || txn_wr_byte !== 8'hBB || txn_dev !== 7'h00) begin
            $display("FAIL post_rst_txn: got addr=%h len=%0d b1=%h dev=%h want 1234/2/bb/00",
                     txn_addr, txn_len, txn_wr_byte, txn_dev);
            tests_failed++;
        end
        @(negedge clk);
        finish_txn(1'b0);
        run_upload(1'b0, "post_rst");
    endtask

    initial begin
        test_reset();
        test_config_read();
        test_write_nack();
        test_timeout();
        test_trunc_toggle();
        test_write_addr_8bit();
        test_reset_mid_upload();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_engine.md
I2C_CMD_ENGINE -- requirements
Module: i2c_cmd_engine

Interface
REQ-001 SHALL have parameter SYS_CLK_FREQ, 50_000_000, system clock in Hz.
REQ-002 SHALL have parameter BUF_DEPTH, 64, write/read buffer depth in bytes (power of 2, 4..256).
REQ-003 SHALL have parameter TIMEOUT_CYC, 1_000_000, max clk cycles from txn_req to txn_done.
REQ-004 SHALL have parameter DATA_SRC, 8'h05, upload_source for read data bytes.
REQ-005 SHALL have parameter STAT_SRC, 8'h06, upload_source for status byte.
REQ-006 SHALL have ports, in order:
- clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low
- cmd_type  in  8  command code; cmd_length  in  16  payload bytes
- cmd_data  in  8  payload byte; cmd_data_index  in  16  byte index
- cmd_start  in  1  command start pulse; cmd_data_valid  in  1  cmd_data valid; cmd_done  in  1  end-of-payload pulse
- cmd_ready  out  1  engine accepts command/payload
- txn_req  out  1  one-cycle transaction start to bit-level master; txn_rw  out  1  1=read
- txn_dev  out  7  device address; txn_use_addr  out  1  send register address; txn_addr  out  16; txn_addr16  out  1  16-bit register address
- txn_len  out  16  data bytes; scl_div  out  16  quarter-period divider
- txn_wr_idx  in  8  write byte index; txn_wr_byte  out  8  write_buffer[txn_wr_idx], combinational
- txn_rd_valid  in  1; txn_rd_byte  in  8  read byte, stored at next read index
- txn_done  in  1  completion pulse; txn_nack  in  1  valid with txn_done; txn_abort  out  1  one-cycle abort on timeout
- upload_active  out  1; upload_req  out  1; upload_data  out  8; upload_source  out  8; upload_valid  out  1; upload_ready  in  1

Function
REQ-007 SHALL decode on cmd_start in IDLE: 0x02 write-noaddr, 0x03 read-noaddr, 0x04 config, 0x05 write-addr, 0x06 read-addr; other codes ignored, stay IDLE.
REQ-008 SHALL use FSM IDLE -> PARSE -> EXEC -> UPLOAD -> STATUS -> IDLE; config goes PARSE -> IDLE on cmd_done; cmd_ready=1 only in IDLE and PARSE.
REQ-009 SHALL parse config payload [dev, mode, scl_code]: mode 1=16-bit else 8-bit; scl_code 1/2/3 set scl_div=SYS_CLK_FREQ/(4*100k/400k/1M)-1; other codes keep scl_div.
REQ-010 SHALL parse write-addr as [addr_hi, addr_lo, data...]; in 8-bit mode txn_addr={8'h00, addr_lo}; data stored at index-2.
REQ-011 SHALL parse read payload as [len_hi, len_lo] (noaddr) or [addr_hi, addr_lo, len_hi, len_lo] (addr).
REQ-012 SHALL drop write bytes with buffer index >= BUF_DEPTH and clamp txn_len to BUF_DEPTH, setting status bit2 (truncated).
REQ-013 SHALL, for txn_len=0, skip EXEC and go directly to STATUS.
REQ-014 SHALL assert txn_req exactly one cycle on EXEC entry, with txn_* outputs stable from then until txn_done or txn_abort.
REQ-015 SHALL leave EXEC on txn_done (status bit0 = txn_nack) or, after TIMEOUT_CYC cycles without txn_done, pulse txn_abort and set status bit1.
REQ-016 SHALL store txn_rd_byte at incrementing index on txn_rd_valid; bytes beyond txn_len ignored.
REQ-017 SHALL enter UPLOAD only for reads completing without NACK/timeout; otherwise go to STATUS.
REQ-018 SHALL hold upload_valid with upload_data stable until the cycle upload_valid&&upload_ready, then advance; one byte per accepted cycle max.
REQ-019 SHALL upload txn_len data bytes (source DATA_SRC) then one status byte {5'b0, trunc, timeout, nack} (source STAT_SRC) for every read and write.
REQ-020 SHALL drive upload_req and upload_active high throughout UPLOAD and STATUS, low otherwise.
REQ-021 SHALL clear status bits on every cmd_start accepted in IDLE.
REQ-022 SHALL ignore txn_done outside EXEC and cmd_start outside IDLE.

Reset
REQ-023 SHALL on rst_n low enter IDLE immediately, including mid-transaction or mid-upload, without issuing txn_abort.
REQ-024 SHALL reset outputs: cmd_ready=1, txn_req=0, txn_abort=0, upload_req/active/valid=0, upload_data=0, upload_source=DATA_SRC, scl_div=SYS_CLK_FREQ/400_000-1 (124 at default), txn_addr16=1, txn_dev=0, status=0.

Verification
REQ-025 Config [0x50,1,2] then read-addr [0x00,0x10,0x00,0x03], controller returns A1,B2,C3 with txn_done/nack=0 -> txn_dev=0x50, txn_addr=0x0010, txn_len=3, uploads A1,B2,C3 (src 05) then 0x00 (src 06).
REQ-026 Write-noaddr 4 bytes 11,22,33,44, txn_done with nack=1 -> txn_wr_byte at idx 0..3 = 11..44, single status upload 0x01, no data upload.
REQ-027 Read with txn_done withheld, TIMEOUT_CYC=100 -> txn_abort pulse at cycle 100 after txn_req, status 0x02 uploaded.
REQ-028 Read-noaddr len 0x0050 with BUF_DEPTH=64 -> txn_len=64, 64 data bytes then status 0x04; upload_ready toggled every other cycle -> no byte lost or duplicated.
REQ-029 rst_n asserted during UPLOAD byte 2 of 3 -> next cycle IDLE, upload_valid=0, cmd_ready=1; subsequent command runs normally.
